alu_sequencer: RTL and testbench
================================

# alu_sequencer

Parametrised successor to the fixed-formula W-accumulator datapath. It fetches packed operand words from an external program ROM, evaluates one of four selectable three-step formulas on each word, and reports every result with a valid pulse. A start/busy/done handshake frames each run, and the block keeps a sticky divide-by-zero flag and a run cycle counter. It sits between the program ROM and the downstream result consumer, replacing the hard-wired `(a + d) * b - c` sequencer.

## Interface
- DATA_W, 8, accumulator and result width; must be ≥ OPND_W.
- OPND_W, 4, width of each packed operand a/b/c/d.
- ADDR_W, 4, ROM address width; also the width of `len` and `res_idx`.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  run request; sampled only in IDLE.
- mode  in  2  formula select; latched on an accepted start.
- len  in  ADDR_W  number of ROM words to process; latched on an accepted start.
- rom_addr  out  ADDR_W  ROM address equal to the PC; the ROM is combinational (read in the same cycle).
- rom_data  in  4*OPND_W  operand word: a=[OPND_W-1:0], b next field up, c next, d=top field.
- busy  out  1  high whenever state ≠ IDLE.
- res_valid  out  1  one-cycle pulse; `result` and `res_idx` are valid while it is high.
- result  out  DATA_W  accumulator W; holds its value between updates.
- res_idx  out  ADDR_W  ROM address of the word that produced `result`.
- done  out  1  one-cycle end-of-run pulse.
- dz_flag  out  1  sticky divide-by-zero flag; cleared on an accepted start.
- cyc_cnt  out  16  number of cycles spent busy in the current or last run; saturates at 0xFFFF.

## Operation
- States:
  - IDLE → FETCH on start when len ≠ 0.
  - IDLE → FIN on start when len = 0.
  - FETCH → S1 → S2 → S3.
  - S3 → FETCH while words remain, otherwise S3 → FIN.
  - FIN → IDLE.
- Accepted start: clear PC, `dz_flag` and `cyc_cnt`; latch `mode` and `len`.
- FETCH: latch a/b/c/d from `rom_data` at `rom_addr` = PC, then increment the PC.
- S1: W ← a OP1 y1. S2: W ← W OP2 y2. S3: W ← W OP3 y3.
- Recipes (op, y):
  - mode0: (+,d), (×,b), (−,c), i.e. (a+d)·b−c.
  - mode1: (−,b), (×,c), (+,d).
  - mode2: (×,b), (÷,c), (+,d).
  - mode3: (+,b), (+,c), (+,d).
- Arithmetic:
  - Operands are zero-extended to DATA_W.
  - +, −, × are unsigned modulo 2^DATA_W (truncate to DATA_W).
  - ÷ is unsigned integer division.
  - Division by 0 gives W = all ones and sets `dz_flag`.
- A start while busy is ignored. `mode` and `len` changes after acceptance have no effect on the run.
- PC wraps modulo 2^ADDR_W; len = 2^ADDR_W−1 processes addresses 0..len−1.
- Reset values: PC=0, W=0, state IDLE; `busy`, `res_valid`, `done`, `dz_flag` = 0; `cyc_cnt`=0; `res_idx`=0.
- rst low mid-run: full reset at that edge, no `done` pulse, no `res_valid` pulse.

## Timing
- Start accepted at edge E: `busy` is high from E onward.
- Each word takes 4 cycles (FETCH, S1, S2, S3).
- `res_valid` is registered. For the first word it is high in the cycle after the S3 edge, i.e. at E+5 with len ≥ 1, overlapping the next FETCH or FIN.
- Word k's `res_valid` is at E+5+4k.
- `done` is high during the FIN cycle; for the last word it coincides with that word's `res_valid`. `busy` is low on the following cycle.
- len=0: FIN at E+1, `done` pulse there, no results.
- `cyc_cnt` increments every cycle while `busy`: a run of len words ends with `cyc_cnt` = 4·len+1.

## Configuration
- ALU_SEQ_DIV_EN defined: ÷ is implemented as above.
- ALU_SEQ_DIV_EN undefined:
  - No divider is synthesised.
  - ÷ steps leave W unchanged.
  - `dz_flag` is tied to 0.
  - mode2 therefore computes a·b+d.

## Structure
- Package `alu_seq_pkg`:
  - `op_t` enum: ADD, SUB, MUL, DIV.
  - `ysel_t` enum: B, C, D.
  - `state_t` enum.
  - `RECIPE` constant: a 4×3 array of {op_t, ysel_t}.
- Sub-module `seq_alu`: purely combinational (x, y, op) → (s, dz). It contains the ALU_SEQ_DIV_EN guard.
- Top-level contents: FSM, PC, operand registers, W, handshake outputs and counter.

## Test plan
- DATA_W=8, mode0, one word a=3,b=2,c=1,d=4 → `result`=13 at E+5, `res_idx`=0, `done` same cycle, `cyc_cnt`=5.
- mode1, a=1,b=3,c=2,d=0 → 0xFE, then 0x1FC truncated to 0xFC → `result`=252, `dz_flag`=0.
- mode2 with DIV_EN, a=6,b=5,c=0,d=2 → 0xFF+2 wraps to `result`=1, `dz_flag`=1 and stays 1 until the next start. Without DIV_EN → `result`=32, `dz_flag`=0.
- mode3, len=3, ROM words sum to 10, 20, 30 → three `res_valid` pulses 4 cycles apart with `res_idx` 0,1,2; `done` with the third; `cyc_cnt`=13; start pulses during the run are ignored.
- len=0 → `done` one cycle after start, no `res_valid`, `cyc_cnt`=1.
- rst low during S2 of word 1 → next cycle all outputs are at reset values and no `done` pulse occurs. A following start with len=1 runs normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for alu_sequencer: ALU ops, operand selects, FSM states and
// the per-mode three-step formula table.
package alu_seq_pkg;

    typedef enum logic [1:0] {ADD, SUB, MUL, DIV} op_t;
    typedef enum logic [1:0] {B, C, D} ysel_t;
    typedef enum logic [2:0] {IDLE, FETCH, S1, S2, S3, FIN} state_t;

    typedef struct packed {
        op_t   op;
        ysel_t ysel;
    } step_t;

    // Row = mode, column = step (S1, S2, S3); the S1 x operand is always a.
    localparam step_t RECIPE [4][3] = '{
        '{'{ADD, D}, '{MUL, B}, '{SUB, C}},
        '{'{SUB, B}, '{MUL, C}, '{ADD, D}},
        '{'{MUL, B}, '{DIV, C}, '{ADD, D}},
        '{'{ADD, B}, '{ADD, C}, '{ADD, D}}
    };

endpackage

// File: rtl/seq_alu.sv
// Combinational single-step ALU for alu_sequencer. The divider exists only
// when ALU_SEQ_DIV_EN is defined; otherwise DIV passes x through.
module seq_alu
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  op_t               op,
    output logic [DATA_W-1:0] s,
    output logic              dz
);

    always_comb begin
        s  = x;
        dz = 1'b0;
        case (op)
            ADD: s = x + y;
            SUB: s = x - y;
            MUL: s = x * y;
            DIV: begin
`ifdef ALU_SEQ_DIV_EN
                if (y == '0) begin
                    s  = '1;
                    dz = 1'b1;
                end else begin
                    s = x / y;
                end
`else
                s = x;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// ROM-driven formula sequencer: fetches packed a/b/c/d words, runs a per-mode
// three-step recipe on each, and pulses every result. ALU_SEQ_DIV_EN enables ÷.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OPND_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [ADDR_W-1:0]   len,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [4*OPND_W-1:0] rom_data,
    output logic                busy,
    output logic                res_valid,
    output logic [DATA_W-1:0]   result,
    output logic [ADDR_W-1:0]   res_idx,
    output logic                done,
    output logic                dz_flag,
    output logic [15:0]         cyc_cnt
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, len_q, idx_q;
    logic [1:0]          mode_q;
    logic [OPND_W-1:0]   a_q, b_q, c_q, d_q;
    logic [DATA_W-1:0]   w;
    logic [1:0]          step;
    step_t               rcp;
    logic [DATA_W-1:0]   alu_x, alu_y, alu_s;
    logic                alu_dz;

    assign busy     = (state != IDLE);
    assign done     = (state == FIN);
    assign rom_addr = pc;
    assign result   = w;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len == '0) ? FIN : FETCH;
            FETCH:   state_nxt = S1;
            S1:      state_nxt = S2;
            S2:      state_nxt = S3;
            S3:      state_nxt = (pc == len_q) ? FIN : FETCH;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        step = 2'd0;
        if (state == S2) step = 2'd1;
        if (state == S3) step = 2'd2;
    end

    assign rcp   = RECIPE[mode_q][step];
    assign alu_x = (state == S1) ? DATA_W'(a_q) : w;

    always_comb begin
        alu_y = DATA_W'(d_q);
        case (rcp.ysel)
            B:       alu_y = DATA_W'(b_q);
            C:       alu_y = DATA_W'(c_q);
            D:       alu_y = DATA_W'(d_q);
            default: ;
        endcase
    end

    seq_alu #(.DATA_W(DATA_W)) u_alu (
        .x  (alu_x),
        .y  (alu_y),
        .op (rcp.op),
        .s  (alu_s),
        .dz (alu_dz)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc        <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            mode_q    <= '0;
            {d_q, c_q, b_q, a_q} <= '0;
            w         <= '0;
            res_valid <= 1'b0;
            res_idx   <= '0;
            dz_flag   <= 1'b0;
            cyc_cnt   <= '0;
        end else begin
            res_valid <= 1'b0;
            if (busy && cyc_cnt != 16'hFFFF) cyc_cnt <= cyc_cnt + 16'd1;
            case (state)
                IDLE: if (start) begin
                    pc      <= '0;
                    dz_flag <= 1'b0;
                    cyc_cnt <= '0;
                    mode_q  <= mode;
                    len_q   <= len;
                end
                FETCH: begin
                    {d_q, c_q, b_q, a_q} <= rom_data;
                    idx_q <= pc;
                    pc    <= pc + 1'b1;
                end
                S1, S2, S3: begin
                    w <= alu_s;
                    if (alu_dz) dz_flag <= 1'b1;
                    if (state == S3) begin
                        res_valid <= 1'b1;
                        res_idx   <= idx_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases plus random runs
// compared cycle-by-cycle against a plain-arithmetic formula model.
module tb_alu_sequencer;

    localparam int DW = 8;
    localparam int OW = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [AW-1:0] len = '0;
    logic [AW-1:0] rom_addr;
    logic [4*OW-1:0] rom_data;
    logic          busy, res_valid, done, dz_flag;
    logic [DW-1:0] result;
    logic [AW-1:0] res_idx;
    logic [15:0]   cyc_cnt;

    logic [15:0] rom [16];
    assign rom_data = rom[rom_addr];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_W(DW), .OPND_W(OW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .len       (len),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .busy      (busy),
        .res_valid (res_valid),
        .result    (result),
        .res_idx   (res_idx),
        .done      (done),
        .dz_flag   (dz_flag),
        .cyc_cnt   (cyc_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pack(input int a, input int b, input int c, input int d);
        logic [3:0] fa, fb, fc, fd;
        fa = 4'(a); fb = 4'(b); fc = 4'(c); fd = 4'(d);
        return {fd, fc, fb, fa};
    endfunction

    // Returns {dz, result} for one word evaluated under the given mode.
    function automatic logic [8:0] model(input logic [1:0] m, input logic [15:0] wd);
        int a, b, c, d, r;
        logic dz;
        a = int'(wd[3:0]); b = int'(wd[7:4]); c = int'(wd[11:8]); d = int'(wd[15:12]);
        dz = 1'b0;
        case (m)
            2'd0: r = (a + d) * b - c;
            2'd1: r = (a - b) * c + d;
            2'd2: begin
`ifdef ALU_SEQ_DIV_EN
                if (c == 0) begin
                    r  = 255 + d;
                    dz = 1'b1;
                end else begin
                    r = ((a * b) % 256) / c + d;
                end
`else
                r = a * b + d;
`endif
            end
            default: r = a + b + c + d;
        endcase
        return {dz, r[7:0]};
    endfunction

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_res_valid"}, res_valid, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_dz"}, dz_flag, 0);
        chk({pfx, "_cyc"}, cyc_cnt, 0);
        chk({pfx, "_result"}, result, 0);
        chk({pfx, "_res_idx"}, res_idx, 0);
        chk({pfx, "_rom_addr"}, rom_addr, 0);
    endtask

    // Called and returns at a negedge. Sample j is the negedge after edge E+j.
    task automatic run(input logic [1:0] m, input int l, input bit spurious, input int rst_at);
        logic [8:0] mr;
        logic dz_acc;
        int last;
        mode  = m;
        len   = 4'(l);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        dz_acc = 1'b0;
        last   = 4 * l;
        for (int j = 0; j <= last + 1; j++) begin
            chk("busy", busy, 32'(j <= last));
            chk("done", done, 32'(j == last));
            chk("res_valid", res_valid, 32'(j >= 4 && j % 4 == 0 && j <= last));
            chk("cyc_cnt", cyc_cnt, j);
            if (j == 0) chk("dz_clear", dz_flag, 0);
            if (j < last && j % 4 == 0) chk("rom_addr", rom_addr, j / 4);
            if (j >= 4 && j % 4 == 0 && j <= last) begin
                mr = model(m, rom[j/4-1]);
                dz_acc = dz_acc | mr[8];
                chk("result", result, mr[7:0]);
                chk("res_idx", res_idx, j / 4 - 1);
                chk("dz_flag", dz_flag, dz_acc);
            end
            if (j == rst_at) begin
                rst = 1'b0;
                @(negedge clk);
                chk_reset_vals("abort");
                rst = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_no_done", done, 0);
                    chk("abort_no_valid", res_valid, 0);
                end
                return;
            end
            start = (spurious && j < last) ? 1'($urandom) : 1'b0;
            mode  = 2'($urandom);
            len   = 4'($urandom);
            @(negedge clk);
        end
        chk("dz_final", dz_flag, dz_acc);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);

        rom[0] = pack(3, 2, 1, 4);
        run(2'd0, 1, 1'b0, -1);
        chk("m0_result", result, 13);
        chk("m0_cyc", cyc_cnt, 5);

        rom[0] = pack(1, 3, 2, 0);
        run(2'd1, 1, 1'b0, -1);
        chk("m1_result", result, 252);
        chk("m1_dz", dz_flag, 0);

        rom[0] = pack(6, 5, 0, 2);
        run(2'd2, 1, 1'b0, -1);
`ifdef ALU_SEQ_DIV_EN
        chk("m2_result", result, 1);
        repeat (3) @(negedge clk);
        chk("m2_dz_sticky", dz_flag, 1);
`else
        chk("m2_result", result, 32);
        repeat (3) @(negedge clk);
        chk("m2_dz", dz_flag, 0);
`endif

        rom[0] = pack(1, 2, 3, 4);
        rom[1] = pack(5, 5, 5, 5);
        rom[2] = pack(15, 15, 0, 0);
        run(2'd3, 3, 1'b1, -1);
        chk("m3_result", result, 30);
        chk("m3_cyc", cyc_cnt, 13);

        run(2'd0, 0, 1'b0, -1);
        chk("len0_cyc", cyc_cnt, 1);

        run(2'd3, 3, 1'b0, 6);
        rom[0] = pack(3, 2, 1, 4);
        run(2'd0, 1, 1'b0, -1);
        chk("post_rst_result", result, 13);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
            run(2'($urandom), (r == 0) ? 15 : int'($urandom_range(15, 0)), 1'($urandom), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
